// File: rtl/mmio_ctrl_pipe.sv
// Pipelined MMIO slot controller: registered slot strobes, 2-cycle read return, sticky error log.
// Optional macro MMIO_ERR_IRQ_EN adds a one-cycle err_irq pulse per logged error.
module mmio_ctrl_pipe #(
    parameter int                SLOT_W    = 6,
    parameter int                REG_W     = 5,
    parameter int                N_SLOT    = 64,
    parameter logic [N_SLOT-1:0] SLOT_MASK = {N_SLOT{1'b1}},
    parameter int                ERR_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mmio_cs,
    input  logic                     mmio_wr,
    input  logic                     mmio_rd,
    input  logic [20:0]              mmio_addr,
    input  logic [31:0]              mmio_wr_data,
    output logic [31:0]              mmio_rd_data,
    output logic                     mmio_rd_valid,
    output logic [N_SLOT-1:0]        slot_cs,
    output logic [N_SLOT-1:0]        slot_rd,
    output logic [N_SLOT-1:0]        slot_wr,
    output logic [REG_W-1:0]         slot_reg_addr,
    output logic [31:0]              slot_wr_data,
    input  logic [N_SLOT*32-1:0]     slot_rd_data_1d,
    input  logic                     err_clr,
    output logic                     err_flag,
    output logic [SLOT_W+REG_W-1:0]  err_addr,
    output logic [ERR_CNT_W-1:0]     err_cnt
`ifdef MMIO_ERR_IRQ_EN
   ,output logic                     err_irq
`endif
);
    localparam int AW = SLOT_W + REG_W;

    logic [SLOT_W-1:0] req_slot;
    logic [REG_W-1:0]  req_reg;
    logic              req_valid;
    logic              req_illegal;
    logic              req_mapped;
    logic              req_hit;
    logic              req_error;
    logic [N_SLOT-1:0] req_onehot;
    logic [31:0]       rd_sel;
    logic              rsp_pend;
    logic              rsp_err;
    logic              unused_addr;

    assign req_slot    = mmio_addr[REG_W +: SLOT_W];
    assign req_reg     = mmio_addr[REG_W-1:0];
    assign req_valid   = mmio_cs & (mmio_rd ^ mmio_wr);
    assign req_illegal = mmio_cs & mmio_rd & mmio_wr;
    assign req_hit     = req_valid & req_mapped;
    assign req_error   = (req_valid & ~req_mapped) | req_illegal;
    assign unused_addr = ^mmio_addr[20:AW];

    // Slot decode; indices at or above N_SLOT and masked slots never match.
    always_comb begin
        req_mapped = 1'b0;
        req_onehot = '0;
        for (int i = 0; i < N_SLOT; i++) begin
            if (req_slot == SLOT_W'(i) && SLOT_MASK[i]) begin
                req_mapped    = 1'b1;
                req_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < N_SLOT; i++) begin
            if (slot_rd[i]) rd_sel = rd_sel | slot_rd_data_1d[32*i +: 32];
        end
    end

    // Broadcast register index and data only change when a strobe is actually issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cs       <= '0;
            slot_rd       <= '0;
            slot_wr       <= '0;
            slot_reg_addr <= '0;
            slot_wr_data  <= '0;
            rsp_pend      <= 1'b0;
            rsp_err       <= 1'b0;
            mmio_rd_valid <= 1'b0;
            mmio_rd_data  <= '0;
        end else begin
            slot_cs <= req_hit ? req_onehot : '0;
            slot_rd <= (req_hit & mmio_rd) ? req_onehot : '0;
            slot_wr <= (req_hit & mmio_wr) ? req_onehot : '0;
            if (req_hit) begin
                slot_reg_addr <= req_reg;
                slot_wr_data  <= mmio_wr_data;
            end
            rsp_pend      <= mmio_cs & mmio_rd;
            rsp_err       <= ~req_hit;
            mmio_rd_valid <= rsp_pend;
            if (rsp_pend) mmio_rd_data <= rsp_err ? 32'hFFFF_FFFF : rd_sel;
        end
    end

    // A new error takes priority over err_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_flag <= 1'b0;
            err_addr <= '0;
            err_cnt  <= '0;
        end else if (req_error) begin
            err_flag <= 1'b1;
            err_addr <= mmio_addr[AW-1:0];
            if (err_clr)
                err_cnt <= ERR_CNT_W'(1);
            else if (err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end else if (err_clr) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end
    end

`ifdef MMIO_ERR_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) err_irq <= 1'b0;
        else       err_irq <= req_error;
    end
`endif

endmodule

// File: tb/tb_mmio_ctrl_pipe.sv
// Randomized self-checking bench for mmio_ctrl_pipe against a cycle-level reference model.
// Honours MMIO_ERR_IRQ_EN when the design is built with it.
module tb_mmio_ctrl_pipe;
    localparam int          N       = 12;
    localparam int          SW      = 6;
    localparam int          RW      = 5;
    localparam int          CW      = 2;
    localparam int          AW      = SW + RW;
    localparam logic [N-1:0] MASK   = 12'hB7F;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              mmio_cs = 1'b0, mmio_wr = 1'b0, mmio_rd = 1'b0;
    logic [20:0]       mmio_addr = '0;
    logic [31:0]       mmio_wr_data = '0;
    logic [31:0]       mmio_rd_data;
    logic              mmio_rd_valid;
    logic [N-1:0]      slot_cs, slot_rd, slot_wr;
    logic [RW-1:0]     slot_reg_addr;
    logic [31:0]       slot_wr_data;
    logic [N*32-1:0]   slot_rd_data_1d = '0;
    logic              err_clr = 1'b0;
    logic              err_flag;
    logic [AW-1:0]     err_addr;
    logic [CW-1:0]     err_cnt;
`ifdef MMIO_ERR_IRQ_EN
    logic              err_irq;
`endif

    mmio_ctrl_pipe #(.SLOT_W(SW), .REG_W(RW), .N_SLOT(N), .SLOT_MASK(MASK), .ERR_CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
        .mmio_rd_data(mmio_rd_data), .mmio_rd_valid(mmio_rd_valid),
        .slot_cs(slot_cs), .slot_rd(slot_rd), .slot_wr(slot_wr),
        .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data),
        .slot_rd_data_1d(slot_rd_data_1d),
        .err_clr(err_clr), .err_flag(err_flag), .err_addr(err_addr), .err_cnt(err_cnt)
`ifdef MMIO_ERR_IRQ_EN
       ,.err_irq(err_irq)
`endif
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;
    int irqPulses   = 0;
    bit holdData    = 0;
    logic [31:0] sd [N];

    // Reference model: expected outputs after the next edge.
    logic [N-1:0]  eCs, eRd, eWr;
    logic [RW-1:0] eReg;
    logic [31:0]   eWdata, eData;
    logic          eValid, eFlag, eIrq;
    logic [AW-1:0] eAddr;
    int            eCnt;
    bit            p1Rsp, p1Hit;
    int            p1Slot;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic cs, input logic rd, input logic wr, input logic [20:0] addr,
                                 input logic [31:0] wd, input logic clr, input logic rst);
        int slot, rg;
        bit mapped, valid, hit, err;
        mmio_cs = cs; mmio_rd = rd; mmio_wr = wr; mmio_addr = addr;
        mmio_wr_data = wd; err_clr = clr; reset = rst;
        for (int i = 0; i < N; i++) begin
            if (!holdData) sd[i] = $urandom;
            slot_rd_data_1d[32*i +: 32] = sd[i];
        end
        slot   = (int'(addr) >> RW) % (1 << SW);
        rg     = int'(addr) % (1 << RW);
        mapped = (slot < N) && MASK[slot];
        valid  = cs && (rd != wr);
        hit    = valid && mapped;
        err    = cs && ((rd && wr) || (valid && !mapped));
        if (rst) begin
            eCs = '0; eRd = '0; eWr = '0; eReg = '0; eWdata = '0;
            eValid = 0; eData = '0; eFlag = 0; eAddr = '0; eCnt = 0; eIrq = 0;
            p1Rsp = 0; p1Hit = 0; p1Slot = 0;
        end else begin
            eValid = p1Rsp;
            if (p1Rsp) eData = p1Hit ? sd[p1Slot] : 32'hFFFF_FFFF;
            p1Rsp = cs && rd; p1Hit = hit; p1Slot = slot;
            eCs = hit ? N'(1) << slot : '0;
            eRd = (hit && rd) ? eCs : '0;
            eWr = (hit && wr) ? eCs : '0;
            if (hit) begin eReg = RW'(rg); eWdata = wd; end
            eIrq = err;
            if (err) begin
                eFlag = 1; eAddr = addr[AW-1:0];
                eCnt  = clr ? 1 : (eCnt == CNT_MAX ? CNT_MAX : eCnt + 1);
            end else if (clr) begin
                eFlag = 0; eCnt = 0;
            end
        end
        @(posedge clk); #1;
        checkOutput("slot_cs", slot_cs, eCs);
        checkOutput("slot_rd", slot_rd, eRd);
        checkOutput("slot_wr", slot_wr, eWr);
        checkOutput("slot_reg_addr", slot_reg_addr, eReg);
        checkOutput("slot_wr_data", slot_wr_data, eWdata);
        checkOutput("rd_valid", mmio_rd_valid, eValid);
        checkOutput("rd_data", mmio_rd_data, eData);
        checkOutput("err_flag", err_flag, eFlag);
        checkOutput("err_addr", err_addr, eAddr);
        checkOutput("err_cnt", err_cnt, eCnt);
`ifdef MMIO_ERR_IRQ_EN
        checkOutput("err_irq", err_irq, eIrq);
        if (err_irq) irqPulses++;
`endif
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, '0, '0, 0, 0);
    endtask

    initial begin
        logic [20:0] a;
        applyStimulus(0, 0, 0, '0, '0, 0, 1);
        applyStimulus(0, 0, 0, '0, '0, 0, 1);
        checkOutput("reset_cs", slot_cs, 0);
        checkOutput("reset_valid", mmio_rd_valid, 0);

        // Write slot 2 reg 3
        applyStimulus(1, 0, 1, 21'h043, 32'hA5A5_0001, 0, 0);
        checkOutput("t1_cs", slot_cs, 12'h004);
        checkOutput("t1_wr", slot_wr, 12'h004);
        checkOutput("t1_reg", slot_reg_addr, 3);
        checkOutput("t1_wdata", slot_wr_data, 32'hA5A5_0001);
        checkOutput("t1_cnt", err_cnt, 0);
        idle();

        // Back-to-back reads, slot 3 then slot 0
        holdData = 1;
        sd[3] = 32'h0000_00F0; sd[0] = 32'h1234_5678;
        applyStimulus(1, 1, 0, 21'h060, '0, 0, 0);
        applyStimulus(1, 1, 0, 21'h000, '0, 0, 0);
        checkOutput("t2_valid0", mmio_rd_valid, 1);
        checkOutput("t2_data0", mmio_rd_data, 32'h0000_00F0);
        idle();
        checkOutput("t2_valid1", mmio_rd_valid, 1);
        checkOutput("t2_data1", mmio_rd_data, 32'h1234_5678);
        idle();
        checkOutput("t2_hold_valid", mmio_rd_valid, 0);
        checkOutput("t2_hold_data", mmio_rd_data, 32'h1234_5678);
        holdData = 0;

        // Read from masked slot 7
        applyStimulus(0, 0, 0, '0, '0, 0, 1);
        applyStimulus(1, 1, 0, 21'h0E0, '0, 0, 0);
        checkOutput("t3_cs", slot_cs, 0);
        checkOutput("t3_flag", err_flag, 1);
        checkOutput("t3_addr", err_addr, 11'h0E0);
        checkOutput("t3_cnt", err_cnt, 1);
        idle();
        checkOutput("t3_data", mmio_rd_data, 32'hFFFF_FFFF);

        // Illegal cycle, then err_clr colliding with an unmapped write
        applyStimulus(1, 1, 1, 21'h021, '0, 0, 0);
        checkOutput("t4_cs", slot_cs, 0);
        checkOutput("t4_cnt", err_cnt, 2);
        idle();
        checkOutput("t4_valid", mmio_rd_valid, 1);
        checkOutput("t4_data", mmio_rd_data, 32'hFFFF_FFFF);
        applyStimulus(1, 0, 1, 21'h280, 32'h1, 1, 0);
        checkOutput("t4_clr_cnt", err_cnt, 1);
        checkOutput("t4_clr_flag", err_flag, 1);

        // Saturation of the 2-bit counter
        applyStimulus(0, 0, 0, '0, '0, 0, 1);
        irqPulses = 0;
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, (i % 2) ? 21'h0E1 : 21'h282, 32'(i), 0, 0);
        checkOutput("t5_cnt", err_cnt, 3);
`ifdef MMIO_ERR_IRQ_EN
        checkOutput("t5_irq", irqPulses, 5);
`endif

        // Reset during an in-flight read
        applyStimulus(1, 1, 0, 21'h041, '0, 0, 0);
        applyStimulus(0, 0, 0, '0, '0, 0, 1);
        checkOutput("t6_cnt", err_cnt, 0);
        checkOutput("t6_data", mmio_rd_data, 0);
        idle();
        checkOutput("t6_valid", mmio_rd_valid, 0);
        holdData = 1; sd[2] = 32'hCAFE_0002;
        applyStimulus(1, 1, 0, 21'h041, '0, 0, 0);
        idle();
        checkOutput("t6_after_valid", mmio_rd_valid, 1);
        checkOutput("t6_after_data", mmio_rd_data, 32'hCAFE_0002);
        holdData = 0;

        for (int c = 0; c < 600; c++) begin
            int s;
            s = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 15);
            a = {10'($urandom), 6'(s), 5'($urandom)};
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), a, $urandom,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 63) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
